nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Multi-cycle unsigned/two's-complement subtractor that computes `a - b` four bits per clock. Each nibble is produced by a carry-select subtract slice, and a registered borrow ripples between slices across cycles. It is the subtract-side counterpart of the team's 4-bit carry-select adder. It sits behind a valid/ready request port and a valid/ready result port, so area-constrained datapaths can trade latency for a single shared slice.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and at least 4.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start_valid`  input  1: request carries valid operands.
- `start_ready`  output  1: block can accept a request.
- `a`  input  WIDTH: minuend.
- `b`  input  WIDTH: subtrahend.
- `done_valid`  output  1: result outputs are valid.
- `done_ready`  input  1: consumer accepts the result.
- `diff`  output  WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow_out`  output  1: set when a < b (unsigned).
- `overflow`  output  1: signed overflow, i.e. `a[MSB] != b[MSB] && diff[MSB] != a[MSB]`.

## Operation
- N = WIDTH/4 slices. The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - `start_ready` = 1.
  - On `start_valid && start_ready`, capture `a` and `b`, clear the nibble index and the borrow register, and go to BUSY.
- BUSY:
  - Each cycle, slice k (LSB first) computes `a[4k+3:4k] - b[4k+3:4k]` for borrow-in 0 and borrow-in 1 in parallel.
  - The registered borrow selects the nibble result and the borrow-out.
  - The selected nibble is written to `diff[4k+3:4k]`, the borrow register updates, and the index increments.
  - After slice N-1, latch `borrow_out` and `overflow`, then go to DONE.
- DONE:
  - `done_valid` = 1.
  - `diff`, `borrow_out` and `overflow` are held stable.
  - On `done_valid && done_ready`, go to IDLE.
- `start_ready` is 0 in BUSY and DONE. `start_valid` is ignored there.
- Operand inputs are don't-care after capture. Changes during BUSY have no effect.
- Slice arithmetic: `x - y - bin` = `x + ~y + ~bin` (5-bit sum). Slice borrow-out = NOT of the carry-out.
- Final `borrow_out` = borrow register after the last slice.

## Timing
- Reset values: state IDLE, `start_ready` 1, `done_valid` 0, `diff` 0, `borrow_out` 0, `overflow` 0, index 0, borrow 0.
- Reset is asynchronous. Asserting `rst_n` low mid-BUSY or mid-DONE aborts the operation immediately, with no partial result visible afterwards.
- Latency: request accepted at edge E. Slices complete at edges E+1 … E+N. `done_valid` is high from edge E+N. For WIDTH=16, `done_valid` rises 4 cycles after acceptance.
- `diff` upper nibbles show stale or zero data during BUSY. They are valid only while `done_valid` is high.
- No same-cycle turnaround: the result handshake at edge R gives `start_ready` = 1 after R. The earliest next acceptance is edge R+1.
- Throughput: one result per N+2 cycles with `done_ready` tied high.
- Back-pressure: `done_ready` low holds DONE indefinitely, with outputs unchanged.

## Structure
- Shared package `sub_pkg`:
  - `SLICE_W = 4`.
  - State enum `sub_state_t {IDLE, BUSY, DONE}`.
  - Index width function `clog2(WIDTH/4)`.
- One sub-module `csel_sub4`, purely combinational:
  - Inputs: 4-bit x, 4-bit y, bin.
  - Outputs: 4-bit d, bout.
  - Internally two 4-bit subtract chains (bin = 0 and bin = 1) plus 2:1 muxes selected by bin.
- The top level instantiates `csel_sub4` once. It holds the FSM, operand registers, nibble index, borrow register and result registers.

## Test plan
- Basic subtract: WIDTH=16, `a`=16'h1234, `b`=16'h0234. Expect `diff`=16'h1000, `borrow_out`=0, `overflow`=0, with `done_valid` exactly 4 cycles after acceptance.
- Full borrow ripple: `a`=16'h0000, `b`=16'h0001. Expect `diff`=16'hFFFF, `borrow_out`=1, `overflow`=0.
- Signed overflow: `a`=16'h8000, `b`=16'h0001. Expect `diff`=16'h7FFF, `borrow_out`=0, `overflow`=1.
- Equal operands with input churn: `a`=`b`=16'hBEEF, then toggle `a` and `b` randomly during BUSY. Expect `diff`=0, `borrow_out`=0, `overflow`=0.
- Back-pressure: hold `done_ready` low 5 cycles while pulsing `start_valid`. Expect outputs stable, `start_ready`=0 throughout, the extra request not accepted, and `start_ready`=1 one cycle after the result handshake.
- Reset abort: drop `rst_n` during the 2nd BUSY cycle. Expect all outputs at reset values immediately. The next request (16'h0010 - 16'h0001) gives 16'h000F.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Provides the slice width, the FSM state type and the nibble index sizing helper.
package sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Index width for WIDTH/4 slices; a single slice still needs a 1-bit index.
  function automatic int idx_w(input int width);
    int n;
    n = width / SLICE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_csel_sub4.sv
// Combinational 4-bit carry-select subtract slice: both borrow-in cases are
// computed in parallel and the real borrow-in picks the result.
module csel_sub4
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W:0] sum_b0;
  logic [SLICE_W:0] sum_b1;

  // x - y - bin == x + ~y + ~bin; the slice borrow is the inverted carry.
  always_comb begin
    sum_b0 = {1'b0, x} + {1'b0, ~y} + {{SLICE_W{1'b0}}, 1'b1};
    sum_b1 = {1'b0, x} + {1'b0, ~y};
  end

  always_comb begin
    d    = bin ? sum_b1[SLICE_W-1:0] : sum_b0[SLICE_W-1:0];
    bout = bin ? ~sum_b1[SLICE_W]    : ~sum_b0[SLICE_W];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor producing a - b one nibble per clock through a single
// shared carry-select slice, with valid/ready request and result ports.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("WIDTH must be a positive multiple of 4");
  end

  sub_state_t state, nxt;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IW-1:0]      idx;
  logic               brw;
  logic [WIDTH-1:0]   diff_q;
  logic               bo_q;
  logic               ov_q;

  logic [IW+1:0]      base;
  logic [SLICE_W-1:0] sl_x;
  logic [SLICE_W-1:0] sl_y;
  logic [SLICE_W-1:0] sl_d;
  logic               sl_bout;
  logic               accept;
  logic               last;

  assign accept = (state == IDLE) && start_valid;
  assign last   = (idx == LAST);
  assign base   = {idx, 2'b00};
  assign sl_x   = a_q[base +: SLICE_W];
  assign sl_y   = b_q[base +: SLICE_W];

  csel_sub4 u_slice (
    .x    (sl_x),
    .y    (sl_y),
    .bin  (brw),
    .d    (sl_d),
    .bout (sl_bout)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_valid)  nxt = BUSY;
      BUSY:    if (last)         nxt = DONE;
      DONE:    if (done_ready)   nxt = IDLE;
      default:                   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bo_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        idx <= '0;
        brw <= 1'b0;
      end else if (state == BUSY) begin
        diff_q[base +: SLICE_W] <= sl_d;
        brw                     <= sl_bout;
        idx                     <= idx + 1'b1;
        // Flags latch on the final slice, where sl_d holds the result MSB.
        if (last) begin
          bo_q <= sl_bout;
          ov_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sl_d[SLICE_W-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  // Operands are only meaningful after capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign diff        = diff_q;
  assign borrow_out  = bo_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor at WIDTH=16: directed
// vectors, handshake corner cases and randomized operands against a model.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_pass = 0;
  int n_total = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .diff        (diff),
    .borrow_out  (borrow_out),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         ebo;
    logic         eov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer subtraction and the sign rule.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int unsigned r;
    r  = (int'(x) - int'(y)) & 32'hFFFF;
    d  = r[W-1:0];
    bo = (x < y);
    ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
  endtask

  // Issue one request and wait for done_valid; returns the cycle count.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit churn, output int cyc);
    chk("start_ready_before", start_ready, 1'b1);
    a = x; b = y; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    cyc = 0;
    while (!done_valid && cyc < 20) begin
      if (churn) begin a = W'($urandom); b = W'($urandom); end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic finish_hs();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("start_ready_after_hs", start_ready, 1'b1);
    chk("done_valid_after_hs", done_valid, 1'b0);
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ed, input logic ebo, input logic eov, input bit churn);
    int cyc;
    launch(x, y, churn, cyc);
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow_out, ebo);
    chk({tag, "_ovf"}, overflow, eov);
    finish_hs();
  endtask

  initial begin
    int cyc;
    logic [W-1:0] md, held;
    logic mbo, mov;

    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_diff", diff, 16'h0);
    chk("rst_borrow", borrow_out, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_vec($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].ebo, vecs[i].eov, 1'b0);

    // Equal operands with input churn during BUSY
    run_vec("churn", 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Back-pressure with stray requests
    launch(16'h5A5A, 16'h1234, 1'b0, cyc);
    chk("bp_latency", cyc, 4);
    held = diff;
    chk("bp_diff", held, 16'h4826);
    for (int k = 0; k < 5; k++) begin
      start_valid = k[0];
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("bp_done_valid", done_valid, 1'b1);
      chk("bp_start_ready", start_ready, 1'b0);
      chk("bp_diff_stable", diff, held);
      chk("bp_borrow_stable", borrow_out, 1'b0);
    end
    start_valid = 1'b0;
    finish_hs();
    @(posedge clk); #1;
    chk("bp_no_extra_accept", {start_ready, done_valid}, 2'b10);

    // Reset abort during the second BUSY cycle
    a = 16'hFFFF; b = 16'h0001; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_start_ready", start_ready, 1'b1);
    chk("abort_done_valid", done_valid, 1'b0);
    chk("abort_diff", diff, 16'h0);
    chk("abort_borrow", borrow_out, 1'b0);
    chk("abort_ovf", overflow, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("post_abort", 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);

    // Randomized operands against the model
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] x, y;
      x = W'($urandom); y = W'($urandom);
      if (t % 8 == 0) y = x;
      model(x, y, md, mbo, mov);
      launch(x, y, t[0], cyc);
      chk("rnd_latency", cyc, 4);
      chk($sformatf("rnd_diff %h-%h", x, y), diff, md);
      chk($sformatf("rnd_borrow %h-%h", x, y), borrow_out, mbo);
      chk($sformatf("rnd_ovf %h-%h", x, y), overflow, mov);
      repeat (t % 3) @(posedge clk);
      #1;
      finish_hs();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
